// File: rtl/uart_probe_dump.sv
// Periodic/triggered probe dumper. It snapshots NUM_CH channels and prints them as one ASCII line over 8N1 UART.
// Optional macro UART_PROBE_DUMP_CHANGE_EN: a periodic tick dumps only when the probes differ from the last snapshot.
module uart_probe_dump #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int NUM_CH     = 8,
  parameter int CH_W       = 16,
  parameter int PERIOD_CYC = 27000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*CH_W-1:0]   probe_bus,
  input  logic [NUM_CH*8-1:0]      probe_tag,
  input  logic                     period_en,
  input  logic                     trigger,
  output logic                     tx_pin,
  output logic                     dumping,
  output logic [15:0]              frame_cnt
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int D   = (CH_W + 3) / 4;
  localparam int DW  = 4 * D;
  localparam int BCW = $clog2(DIV + 1);
  localparam int TW  = $clog2(PERIOD_CYC);
  localparam int CIW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  typedef enum logic [3:0] {F_HASH, F_SEQ, F_SP0, F_TAG, F_COLON, F_DIG, F_SP, F_CR, F_LF} field_t;

  state_t                   state;
  field_t                   field;
  logic [TW-1:0]            timer;
  logic                     pending;
  logic [NUM_CH*CH_W-1:0]   snap_data;
  logic [15:0]              snap_cnt;
  logic [CIW-1:0]           ch_idx;
  logic [2:0]               dig_idx;
  logic                     last_char;
  logic [7:0]               shreg;
  logic [3:0]               bit_cnt;
  logic [BCW-1:0]           baud_cnt;

  logic                     tick_raw;
  logic                     tick;
  logic                     req;
  logic [CH_W-1:0]          ch_val;
  logic [DW-1:0]            ch_pad;
  logic [7:0]               tag_sel;
  logic [3:0]               ch_nib;
  logic [3:0]               seq_nib;
  logic [7:0]               cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign tick_raw = (timer == TW'(PERIOD_CYC - 1)) && period_en;
`ifdef UART_PROBE_DUMP_CHANGE_EN
  // snap_data doubles as the copy of the last dumped snapshot
  assign tick = tick_raw && (probe_bus != snap_data);
`else
  assign tick = tick_raw;
`endif
  assign req = tick | trigger;

  always_comb begin
    ch_val  = '0;
    tag_sel = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CIW'(i)) begin
        ch_val  = snap_data[i*CH_W +: CH_W];
        tag_sel = probe_tag[i*8 +: 8];
      end
    end
    ch_pad = DW'(ch_val);
    ch_nib = 4'h0;
    for (int d = 0; d < D; d++) begin
      if (dig_idx == 3'(d)) ch_nib = ch_pad[(D-1-d)*4 +: 4];
    end
    case (dig_idx[1:0])
      2'd0:    seq_nib = snap_cnt[15:12];
      2'd1:    seq_nib = snap_cnt[11:8];
      2'd2:    seq_nib = snap_cnt[7:4];
      default: seq_nib = snap_cnt[3:0];
    endcase
    case (field)
      F_HASH:  cur_char = 8'h23;
      F_SEQ:   cur_char = hex_ascii(seq_nib);
      F_TAG:   cur_char = tag_sel;
      F_COLON: cur_char = 8'h3A;
      F_DIG:   cur_char = hex_ascii(ch_nib);
      F_CR:    cur_char = 8'h0D;
      F_LF:    cur_char = 8'h0A;
      default: cur_char = 8'h20;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      field     <= F_HASH;
      timer     <= '0;
      pending   <= 1'b0;
      snap_data <= '0;
      snap_cnt  <= '0;
      ch_idx    <= '0;
      dig_idx   <= '0;
      last_char <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      tx_pin    <= 1'b1;
      dumping   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (!period_en || timer == TW'(PERIOD_CYC - 1)) timer <= '0;
      else                                            timer <= timer + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (req || (state == DONE && pending)) begin
            // snapshot cycle: probes and sequence number captured together
            pending   <= 1'b0;
            snap_data <= probe_bus;
            snap_cnt  <= frame_cnt;
            dumping   <= 1'b1;
            field     <= F_HASH;
            ch_idx    <= '0;
            dig_idx   <= '0;
            last_char <= 1'b0;
            state     <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (req) pending <= 1'b1;
          shreg    <= cur_char;
          tx_pin   <= 1'b0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          state    <= SEND;
          case (field)
            F_HASH:  begin field <= F_SEQ; dig_idx <= '0; end
            F_SEQ:   if (dig_idx == 3'd3) field <= F_SP0; else dig_idx <= dig_idx + 1'b1;
            F_SP0:   field <= F_TAG;
            F_TAG:   field <= F_COLON;
            F_COLON: begin field <= F_DIG; dig_idx <= '0; end
            F_DIG: begin
              if (dig_idx == 3'(D - 1))
                field <= (ch_idx == CIW'(NUM_CH - 1)) ? F_CR : F_SP;
              else
                dig_idx <= dig_idx + 1'b1;
            end
            F_SP:    begin field <= F_TAG; ch_idx <= ch_idx + 1'b1; end
            F_CR:    field <= F_LF;
            default: last_char <= 1'b1;
          endcase
        end
        default: begin
          if (req) pending <= 1'b1;
          if (baud_cnt == BCW'(DIV - 1)) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              if (last_char) begin
                state     <= DONE;
                dumping   <= 1'b0;
                frame_cnt <= frame_cnt + 1'b1;
              end else begin
                state <= LOAD;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_pin  <= (bit_cnt == 4'd8) ? 1'b1 : shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_probe_dump.md
Name: uart_probe_dump

Overview:
- Parametrised periodic/triggered debug dumper: snapshots NUM_CH probe channels of CH_W bits each and prints them as one ASCII line over an integrated 8N1 UART transmitter.
- Successor to the fixed-field status printer:
  - generic channel count, width, labels, baud and period
  - sequence-numbered lines
  - on-demand trigger with one-deep pending
- Sits at top level next to the core, driving the debug UART pin.

Parameters:
- CLK_HZ, 27000000, clock frequency in Hz
- BAUD, 115200, serial bit rate; bit divisor DIV = (CLK_HZ + BAUD/2) / BAUD (234 at defaults)
- NUM_CH, 8, probe channel count (1..32)
- CH_W, 16, bits per channel (1..32); hex digits per channel D = ceil(CH_W/4)
- PERIOD_CYC, 27000000, cycles between periodic dump requests (>= 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- probe_bus  in  NUM_CH*CH_W  channel i = bits [i*CH_W +: CH_W]
- probe_tag  in  NUM_CH*8  ASCII label for channel i = bits [i*8 +: 8]; static
- period_en  in  1  enables periodic dumps
- trigger  in  1  single-cycle request for an immediate dump
- tx_pin  out  1  UART serial output, idle high
- dumping  out  1  high from snapshot cycle through the end of the last stop bit
- frame_cnt  out  16  count of completed lines

Behaviour:
- Reset values:
  - tx_pin = 1, dumping = 0, frame_cnt = 0
  - period timer = 0, pending = 0, FSM in IDLE, snapshot registers = 0
- Reset is synchronous:
  - Asserting rst mid-line abandons the line.
  - tx_pin is 1 on the cycle after rst is sampled.
  - No partial character is completed.
- Period timer:
  - Counts 0..PERIOD_CYC-1 while period_en = 1 and wraps to 0.
  - tick = (timer == PERIOD_CYC-1) && period_en.
  - period_en = 0 holds the timer at 0.
- Request = tick | trigger.
  - In IDLE, a request starts a dump in the same cycle.
  - While dumping, a request sets pending. Further requests are absorbed, so there is no counting.
  - At line end, if pending is set, clear it and start the next dump on the following cycle.
- Dump start (snapshot cycle):
  - All of probe_bus and the current frame_cnt are registered together.
  - dumping rises on the next cycle.
  - Later probe changes do not affect the line in flight.
- Line format, characters in order:
  - '#', then 4 hex digits of the snapshotted frame_cnt (MS first), then ' '
  - For ch = 0..NUM_CH-1: tag, ':', then D hex digits MS first, then ' ' if ch < NUM_CH-1
  - Then "\r\n"
  - Hex digits are uppercase 0-9 and A-F.
  - When CH_W is not a multiple of 4, the top nibble is zero-padded.
  - Line length = 6 + NUM_CH*(D+2) + (NUM_CH-1) + 2, which is 63 at defaults.
- FSM states:
  - IDLE -> LOAD on request.
  - LOAD: computes the next character from a field/digit counter in 1 cycle -> SEND.
  - SEND: 10 bit periods of DIV cycles each:
    - 1 start bit (0)
    - 8 data bits, LSB first
    - 1 stop bit (1)
  - SEND -> LOAD if characters remain; otherwise DONE.
  - DONE: frame_cnt += 1 (wraps 0xFFFF -> 0x0000), dumping = 0 -> IDLE, or -> LOAD with pending handling.
- Timing:
  - Each character occupies exactly 10*DIV cycles on tx_pin, plus a 1-cycle LOAD gap during which tx_pin stays 1.
  - First start-bit edge occurs 2 cycles after the request cycle.
- Simultaneous tick and trigger count as one request.
- A trigger in the same cycle as DONE sets pending and results in exactly one more line.

Optional Feature:
- Macro: UART_PROBE_DUMP_CHANGE_EN.
- Defined:
  - Holds a copy of the last dumped snapshot.
  - A periodic tick starts or pends a dump only if the current probe_bus differs from that copy.
  - trigger always dumps.
  - The copy updates at each snapshot.
  - Reset clears the copy to 0.
- Undefined:
  - Every tick dumps.
  - No copy registers exist.

Test Plan:
- Defaults, PERIOD_CYC=400000, probes ch0=16'h1234, tags "ABCDEFGH", others 0, period_en=1 -> after tick, decoded line "#0000 A:1234 B:0000 ... H:0000\r\n" (63 chars); frame_cnt=1 after the stop bit of '\n'.
- trigger pulse in IDLE with period_en=0 -> start bit at request+2 cycles, each bit 234 cycles wide; tx_pin idle high before and after.
- 3 trigger pulses during one line -> exactly one additional line follows, sequence "#0001"; dumping stays high with a 1-cycle low gap between lines.
- NUM_CH=3, CH_W=9, probe ch2=9'h1FF -> field "x:1FF"; ch0=9'h00A prints "00A"; line length 6+15+2+2=25.
- rst asserted mid-character -> tx_pin=1 next cycle, frame_cnt=0, dumping=0; next trigger prints "#0000".
- With UART_PROBE_DUMP_CHANGE_EN: probes static across 3 ticks -> 1 line only; change ch1 -> next tick dumps; trigger with static probes -> dumps.
